// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU operation decoder with a multi-cycle unsigned multiply/divide
// sequencer, HI/LO result registers and a stall request for dependent instructions.
module alu_mdu_ctrl #(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [3:0]       i_aluop,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [3:0]       o_alu_operation,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [3:0] alu_operation;
  logic       is_mdu_op;
  logic       is_launch_op;

  always_comb begin
    alu_operation = 4'h0;
    case (i_aluop)
      4'd0: alu_operation = 4'h0;
      4'd1: alu_operation = 4'h1;
      4'd3: alu_operation = 4'h8;
      4'd4: alu_operation = 4'h7;
      4'd5: alu_operation = 4'hB;
      4'd2: begin
        case (i_funct)
          6'h20: alu_operation = 4'h0;
          6'h22: alu_operation = 4'h1;
          6'h00: alu_operation = 4'h3;
          6'h2A: alu_operation = 4'h4;
          6'h02: alu_operation = 4'h6;
          6'h25: alu_operation = 4'h7;
          6'h24: alu_operation = 4'h8;
          // Without the sequencer the MDU functs fall back to a harmless ADD.
          6'h19: if (MDU_EN) alu_operation = 4'h2;
          6'h1B: if (MDU_EN) alu_operation = 4'hE;
          6'h10: if (MDU_EN) alu_operation = 4'hC;
          6'h12: if (MDU_EN) alu_operation = 4'hD;
          default: alu_operation = 4'h0;
        endcase
      end
      default: alu_operation = 4'h0;
    endcase
  end

  assign o_alu_operation = alu_operation;
  assign is_launch_op    = (alu_operation == 4'h2) || (alu_operation == 4'hE);
  assign is_mdu_op       = is_launch_op || (alu_operation == 4'hC) || (alu_operation == 4'hD);

  generate
    if (MDU_EN) begin : g_mdu
      typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

      state_t             state_q, state_d;
      logic [CW-1:0]      cnt_q, cnt_d;
      logic [2*WIDTH-1:0] acc_q, acc_d;
      logic [WIDTH-1:0]   opb_q, opb_d;
      logic [WIDTH-1:0]   hi_q, hi_d;
      logic [WIDTH-1:0]   lo_q, lo_d;
      logic [WIDTH:0]     mul_sum;
      logic [WIDTH:0]     rem_sh;
      logic [WIDTH-1:0]   div_diff;
      logic               div_ge;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          acc_q   <= '0;
          opb_q   <= '0;
          hi_q    <= '0;
          lo_q    <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          acc_q   <= acc_d;
          opb_q   <= opb_d;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
        end
      end

      // acc holds {partial product | multiplier} or {remainder | dividend/quotient}.
      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (rem_sh >= {1'b0, opb_q});
        div_diff = rem_sh[WIDTH-1:0] - opb_q;
        case (state_q)
          IDLE: begin
            if (i_valid && is_launch_op) begin
              acc_d   = {{WIDTH{1'b0}}, i_op_a};
              opb_d   = i_op_b;
              cnt_d   = CW'(WIDTH);
              state_d = (alu_operation == 4'h2) ? MUL : DIV;
            end
          end
          MUL: begin
            if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
          end
          DIV: begin
            // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
            acc_d = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
          end
          DONE: begin
            hi_d    = acc_q[2*WIDTH-1:WIDTH];
            lo_d    = acc_q[WIDTH-1:0];
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end

      assign o_busy  = (state_q != IDLE);
      assign o_done  = (state_q == DONE);
      assign o_stall = o_busy & i_valid & is_mdu_op;
      assign o_hi    = hi_q;
      assign o_lo    = lo_q;
    end else begin : g_no_mdu
      assign o_busy  = 1'b0;
      assign o_done  = 1'b0;
      assign o_stall = 1'b0;
      assign o_hi    = '0;
      assign o_lo    = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed-vector bench for alu_mdu_ctrl (WIDTH=32): decode table, MULTU/DIVU
// results and latency, stall behaviour, reset abort and back-to-back launches.
module tb_alu_mdu_ctrl;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic [3:0]   i_aluop;
  logic [5:0]   i_funct;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic [3:0]   o_alu_operation;
  logic         o_busy;
  logic         o_done;
  logic         o_stall;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;

  int n_checks = 0;
  int n_pass   = 0;

  alu_mdu_ctrl #(.WIDTH(W), .MDU_EN(1'b1)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .i_aluop         (i_aluop),
    .i_funct         (i_funct),
    .i_op_a          (i_op_a),
    .i_op_b          (i_op_b),
    .o_alu_operation (o_alu_operation),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_stall         (o_stall),
    .o_hi            (o_hi),
    .o_lo            (o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic launch(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    i_valid = 1'b1; i_aluop = 4'd2; i_funct = f; i_op_a = a; i_op_b = b;
    tick();
    i_valid = 1'b0;
  endtask

  // Called 1ns after the launch edge; counts cycles until the sequencer goes idle.
  task automatic run_and_check(input string tag, input int exp_lat,
                               input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int cyc = 1, done_at = 0, busy_cnt = 0;
    while (cyc <= 40) begin
      if (o_busy) busy_cnt++;
      if (o_done && done_at == 0) done_at = cyc;
      if (!o_busy) break;
      tick();
      cyc++;
    end
    if (exp_lat != 0) begin
      chk({tag, "_done_cycle"}, 64'(done_at), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    end
    chk({tag, "_hi"}, 64'(o_hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(o_lo), 64'(exp_lo));
  endtask

  logic [5:0] funct_tbl [12] = '{6'h20, 6'h22, 6'h00, 6'h2A, 6'h02, 6'h25, 6'h24,
                                 6'h19, 6'h1B, 6'h10, 6'h12, 6'h3F};
  logic [3:0] fcode_tbl [12] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8,
                                 4'h2, 4'hE, 4'hC, 4'hD, 4'h0};
  logic [3:0] acode_tbl [8]  = '{4'h0, 4'h1, 4'h0, 4'h8, 4'h7, 4'hB, 4'h0, 4'h0};

  initial begin
    int stall_cnt, launch_cyc, done_cnt;
    i_rst = 1'b1; i_valid = 1'b0; i_aluop = 4'd0; i_funct = 6'h20; i_op_a = '0; i_op_b = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_lo", 64'(o_lo), 64'd0);

    // Decode sweep with i_valid low so nothing launches.
    for (int i = 0; i < 8; i++) begin
      i_aluop = 4'(i); i_funct = 6'h20; #1;
      chk($sformatf("dec_aluop%0d", i), 64'(o_alu_operation), 64'(acode_tbl[i]));
    end
    i_aluop = 4'd2;
    for (int i = 0; i < 12; i++) begin
      i_funct = funct_tbl[i]; #1;
      chk($sformatf("dec_funct%02h", funct_tbl[i]), 64'(o_alu_operation), 64'(fcode_tbl[i]));
    end
    i_funct = 6'h19; tick(); tick();
    chk("novalid_nolaunch", 64'(o_busy), 64'd0);

    // MULTU all-ones.
    launch(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_and_check("mul_ff", 33, 32'hFFFF_FFFE, 32'h0000_0001);

    launch(6'h1B, 32'd100, 32'd7);
    run_and_check("div_100_7", 33, 32'd2, 32'd14);
    launch(6'h1B, 32'h1234, 32'd0);
    run_and_check("div_by0", 33, 32'h0000_1234, 32'hFFFF_FFFF);

    // MFLO waits on an in-flight MULTU; ADD during busy is not stalled.
    launch(6'h19, 32'd3, 32'd5);
    i_valid = 1'b1; i_funct = 6'h12;
    stall_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) begin
        i_funct = 6'h20; #1;
        chk("add_busy_nostall", 64'(o_stall), 64'd0);
        i_funct = 6'h12; #1;
      end
      if (o_stall) stall_cnt++;
      tick();
    end
    chk("mflo_stall_cycles", 64'(stall_cnt), 64'd33);
    chk("mflo_after_nostall", 64'(o_stall), 64'd0);
    chk("mflo_after_lo", 64'(o_lo), 64'd15);
    i_valid = 1'b0; i_funct = 6'h20;
    tick();

    // Reset at compute cycle 10 aborts the operation.
    launch(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c < 10; c++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_hi", 64'(o_hi), 64'd0);
    chk("abort_lo", 64'(o_lo), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) done_cnt++;
      tick();
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);

    // Reset together with a launch: reset wins.
    i_rst = 1'b1;
    launch(6'h19, 32'd2, 32'd2);
    i_rst = 1'b0;
    chk("rst_launch_busy", 64'(o_busy), 64'd0);

    // Back-to-back MULTU then DIVU held by o_stall.
    launch(6'h19, 32'd6, 32'd7);
    i_valid = 1'b1; i_funct = 6'h1B; i_op_a = 32'd100; i_op_b = 32'd9;
    launch_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!o_stall) begin
        launch_cyc = c;
        break;
      end
      tick();
    end
    chk("b2b_launch_cycle", 64'(launch_cyc), 64'd34);
    chk("b2b_mul_hi", 64'(o_hi), 64'd0);
    chk("b2b_mul_lo", 64'(o_lo), 64'd42);
    tick();
    i_valid = 1'b0;
    run_and_check("b2b_div", 33, 32'd1, 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
